// File: rtl/gpr_wb_pkg.sv
// ============================================================================
// Module  : gpr_wb_pkg
// Purpose : Shared widths, active-low enable codes and write-request type
//           for the GPR write-back arbiter slice.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package gpr_wb_pkg;

  localparam int GPR_ADDR_W = 5;
  localparam int GPR_DATA_W = 32;
  localparam int GPR_NUM    = 32;
  localparam int WB_PORTS   = 2;

  // Register-file write enable is active-low.
  localparam logic WE_ENABLE  = 1'b0;
  localparam logic WE_DISABLE = 1'b1;

  typedef struct packed {
    logic [GPR_ADDR_W-1:0] addr;
    logic [GPR_DATA_W-1:0] data;
  } wb_req_t;

endpackage : gpr_wb_pkg

`default_nettype wire

// File: rtl/gpr_scoreboard.sv
// ============================================================================
// Module  : gpr_scoreboard
// Purpose : One pending-write bit per GPR; reservation set beats write clear.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module gpr_scoreboard
  import gpr_wb_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set_valid,
  input  logic [GPR_ADDR_W-1:0] set_addr,
  input  logic                  clr_valid,
  input  logic [GPR_ADDR_W-1:0] clr_addr,
  output logic [GPR_NUM-1:0]    busy
);

  logic [GPR_NUM-1:0] busy_d;
  logic [GPR_NUM-1:0] busy_q;

  for (genvar i = 0; i < GPR_NUM; i++) begin : g_busy_bit
    logic hit_set;
    logic hit_clr;

    assign hit_set = set_valid && (set_addr == GPR_ADDR_W'(i));
    assign hit_clr = clr_valid && (clr_addr == GPR_ADDR_W'(i));

    // A same-edge set means a newer producer was issued, so it wins.
    always_comb begin
      busy_d[i] = busy_q[i];
      if (hit_clr) busy_d[i] = 1'b0;
      if (hit_set) busy_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule : gpr_scoreboard

`default_nettype wire

// File: rtl/gpr_wb_arbiter.sv
// ============================================================================
// Module  : gpr_wb_arbiter
// Purpose : Shares the GPR write port between pipeline (port 0) and
//           multi-cycle unit (port 1) with a starvation guard for port 1.
//           Optional scoreboard: define GPR_WB_SCOREBOARD_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module gpr_wb_arbiter
  import gpr_wb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  wb0_valid,
  input  logic [GPR_ADDR_W-1:0] wb0_addr,
  input  logic [GPR_DATA_W-1:0] wb0_data,
  output logic                  wb0_ready,

  input  logic                  wb1_valid,
  input  logic [GPR_ADDR_W-1:0] wb1_addr,
  input  logic [GPR_DATA_W-1:0] wb1_data,
  output logic                  wb1_ready,

  input  logic                  rsv_valid,
  input  logic [GPR_ADDR_W-1:0] rsv_addr,
  output logic [GPR_NUM-1:0]    busy,

  output logic                  gpr_we_,
  output logic [GPR_ADDR_W-1:0] gpr_wr_addr,
  output logic [GPR_DATA_W-1:0] gpr_wr_data
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_d;
  logic [3:0] starve_cnt_q;
  logic       gpr_we_d;
  logic       gpr_we_q;
  wb_req_t    wr_req_d;
  wb_req_t    wr_req_q;

  logic       starved;
  logic       grant_any;
  wb_req_t    sel_req;

  // Grant looks only at the valids and the counter, never at the output flop.
  assign starved   = (starve_cnt_q == STARVE_MAX);
  assign wb1_ready = !reset && wb1_valid && (starved || !wb0_valid);
  assign wb0_ready = !reset && wb0_valid && !(starved && wb1_valid);
  assign grant_any = wb0_ready || wb1_ready;

  always_comb begin
    sel_req = wb1_ready ? wb_req_t'{addr: wb1_addr, data: wb1_data}
                        : wb_req_t'{addr: wb0_addr, data: wb0_data};
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!wb1_valid || wb1_ready) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q < STARVE_MAX) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_comb begin
    gpr_we_d = WE_DISABLE;
    wr_req_d = wr_req_q;
    if (grant_any) begin
      gpr_we_d = WE_ENABLE;
      wr_req_d = sel_req;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= 4'd0;
      gpr_we_q     <= WE_DISABLE;
      wr_req_q     <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      gpr_we_q     <= gpr_we_d;
      wr_req_q     <= wr_req_d;
    end
  end

  assign gpr_we_     = gpr_we_q;
  assign gpr_wr_addr = wr_req_q.addr;
  assign gpr_wr_data = wr_req_q.data;

`ifdef GPR_WB_SCOREBOARD_EN
  gpr_scoreboard u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .set_valid (rsv_valid),
    .set_addr  (rsv_addr),
    .clr_valid (grant_any),
    .clr_addr  (sel_req.addr),
    .busy      (busy)
  );
`else
  logic unused_rsv;
  assign unused_rsv = ^{rsv_valid, rsv_addr};
  assign busy       = '0;
`endif

endmodule : gpr_wb_arbiter

`default_nettype wire

// File: tb/tb_gpr_wb_arbiter.sv
// ============================================================================
// Module  : tb_gpr_wb_arbiter
// Purpose : Directed self-checking bench for gpr_wb_arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gpr_wb_arbiter;

`ifdef GPR_WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        wb0_valid, wb1_valid, rsv_valid;
  logic [4:0]  wb0_addr, wb1_addr, rsv_addr;
  logic [31:0] wb0_data, wb1_data;
  logic        wb0_ready, wb1_ready, gpr_we_;
  logic [31:0] busy;
  logic [4:0]  gpr_wr_addr;
  logic [31:0] gpr_wr_data;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  gpr_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .wb0_valid   (wb0_valid),
    .wb0_addr    (wb0_addr),
    .wb0_data    (wb0_data),
    .wb0_ready   (wb0_ready),
    .wb1_valid   (wb1_valid),
    .wb1_addr    (wb1_addr),
    .wb1_data    (wb1_data),
    .wb1_ready   (wb1_ready),
    .rsv_valid   (rsv_valid),
    .rsv_addr    (rsv_addr),
    .busy        (busy),
    .gpr_we_     (gpr_we_),
    .gpr_wr_addr (gpr_wr_addr),
    .gpr_wr_data (gpr_wr_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and checks run 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, ".we_"},  32'(gpr_we_), 32'(we));
    chk({tag, ".addr"}, 32'(gpr_wr_addr), 32'(a));
    chk({tag, ".data"}, gpr_wr_data, d);
  endtask

  task automatic chk_rdy(input string tag, input logic r0, input logic r1);
    #1;
    chk({tag, ".rdy0"}, 32'(wb0_ready), 32'(r0));
    chk({tag, ".rdy1"}, 32'(wb1_ready), 32'(r1));
  endtask

  initial begin
    reset = 1'b1;
    wb0_valid = 1'b0; wb0_addr = '0; wb0_data = '0;
    wb1_valid = 1'b0; wb1_addr = '0; wb1_data = '0;
    rsv_valid = 1'b0; rsv_addr = '0;

    // Reset then idle
    tick();
    chk_out("rst1", 1'b1, 5'd0, 32'h0);
    chk("rst1.busy", busy, 32'h0);
    chk_rdy("rst1", 1'b0, 1'b0);
    tick();
    chk_out("rst2", 1'b1, 5'd0, 32'h0);
    reset = 1'b0;
    chk_rdy("idle", 1'b0, 1'b0);
    tick();
    chk_out("idle", 1'b1, 5'd0, 32'h0);
    chk("idle.busy", busy, 32'h0);

    // Single write
    wb0_valid = 1'b1; wb0_addr = 5'd5; wb0_data = 32'hDEADBEEF;
    chk_rdy("single", 1'b1, 1'b0);
    tick();
    wb0_valid = 1'b0;
    chk_out("single.n1", 1'b0, 5'd5, 32'hDEADBEEF);
    tick();
    chk_out("single.n2", 1'b1, 5'd5, 32'hDEADBEEF);

    // Collision: port 0 first, port 1 next cycle
    wb0_valid = 1'b1; wb0_addr = 5'd3; wb0_data = 32'h11;
    wb1_valid = 1'b1; wb1_addr = 5'd4; wb1_data = 32'h22;
    chk_rdy("coll.n0", 1'b1, 1'b0);
    tick();
    wb0_valid = 1'b0;
    chk_out("coll.n1", 1'b0, 5'd3, 32'h11);
    chk_rdy("coll.n1", 1'b0, 1'b1);
    tick();
    wb1_valid = 1'b0;
    chk_out("coll.n2", 1'b0, 5'd4, 32'h22);
    tick();
    chk_out("coll.n3", 1'b1, 5'd4, 32'h22);
    chk("coll.cnt", 32'(dut.starve_cnt_q), 32'd0);

    // Starvation: port 1 waits 4 cycles, then wins once
    wb1_valid = 1'b1; wb1_addr = 5'd20; wb1_data = 32'hAAAA;
    for (int k = 0; k < 4; k++) begin
      wb0_valid = 1'b1; wb0_addr = 5'(10 + k); wb0_data = 32'(k + 100);
      chk_rdy($sformatf("starve.c%0d", k), 1'b1, 1'b0);
      tick();
      chk_out($sformatf("starve.o%0d", k), 1'b0, 5'(10 + k), 32'(k + 100));
    end
    wb0_addr = 5'd14; wb0_data = 32'd104;
    chk_rdy("starve.c4", 1'b0, 1'b1);
    tick();
    wb1_valid = 1'b0;
    chk_out("starve.o4", 1'b0, 5'd20, 32'hAAAA);
    chk("starve.cnt5", 32'(dut.starve_cnt_q), 32'd0);
    chk_rdy("starve.c5", 1'b1, 1'b0);
    tick();
    wb0_valid = 1'b0;
    chk_out("starve.o5", 1'b0, 5'd14, 32'd104);
    tick();
    chk_out("starve.o6", 1'b1, 5'd14, 32'd104);

    // Scoreboard: reserve r7, write it back in cycle 3
    rsv_valid = 1'b1; rsv_addr = 5'd7;
    tick();
    rsv_valid = 1'b0;
    chk("sb.c1", busy, SB ? 32'h80 : 32'h0);
    tick();
    chk("sb.c2", busy, SB ? 32'h80 : 32'h0);
    tick();
    wb1_valid = 1'b1; wb1_addr = 5'd7; wb1_data = 32'h77;
    chk("sb.c3", busy, SB ? 32'h80 : 32'h0);
    chk_rdy("sb.c3", 1'b0, 1'b1);
    tick();
    wb1_valid = 1'b0;
    chk("sb.c4", busy, 32'h0);
    chk_out("sb.wr", 1'b0, 5'd7, 32'h77);

    // Reserve and write r7 on the same edge: set wins
    rsv_valid = 1'b1; rsv_addr = 5'd7;
    wb0_valid = 1'b1; wb0_addr = 5'd7; wb0_data = 32'h700;
    chk_rdy("sb.same", 1'b1, 1'b0);
    tick();
    rsv_valid = 1'b0; wb0_valid = 1'b0;
    chk("sb.same", busy, SB ? 32'h80 : 32'h0);
    chk_out("sb.same", 1'b0, 5'd7, 32'h700);

    // Reset while a request is presented: nothing is written
    reset = 1'b1;
    wb0_valid = 1'b1; wb0_addr = 5'd9; wb0_data = 32'h99;
    chk_rdy("midrst", 1'b0, 1'b0);
    tick();
    reset = 1'b0; wb0_valid = 1'b0;
    chk_out("midrst.n1", 1'b1, 5'd0, 32'h0);
    chk("midrst.busy", busy, 32'h0);
    tick();
    chk_out("midrst.n2", 1'b1, 5'd0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_gpr_wb_arbiter

`default_nettype wire
